// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps one imem read outstanding, holds the fetched
// word until the datapath retires it, then follows npc. Faults are sticky until reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] cpc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_HOLD  = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [7:0] WAIT_LAST      = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_cpc;
  logic        r_valid;
  logic        r_req;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic [31:0] r_retired;
  logic [7:0]  r_wait;

  logic w_npc_aligned;
  assign w_npc_aligned = (npc[1:0] == 2'b00);

  // Coming out of reset the FSM sits in FETCH with the request still low; the
  // first clock raises it, so an ack seen before the request is up is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ins     <= 32'd0;
      r_cpc     <= 32'd0;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_fault   <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_retired <= 32'd0;
      r_wait    <= 8'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_ins   <= imem_rdata;
            r_cpc   <= r_pc;
            r_wait  <= 8'd0;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end else if (r_wait == WAIT_LAST) begin
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_HOLD: begin
          if (ins_ready) begin
            r_retired <= r_retired + 32'd1;
            r_valid   <= 1'b0;
            if (w_npc_aligned) begin
              r_pc    <= npc;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_fault <= 1'b1;
              r_cause <= CAUSE_MISALIGN;
              r_state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_fault <= 1'b1;
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign ins         = r_ins;
  assign cpc         = r_cpc;
  assign ins_valid   = r_valid;
  assign fault       = r_fault;
  assign fault_cause = r_cause;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a scoreboard of fetched words is
// filled when the bench acks a request and drained when ins_valid appears.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] cpc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] npc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;

  fetch_t      sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] expRetired = 32'd0;

  instr_fetch #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .cpc        (cpc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .npc        (npc),
    .fault      (fault),
    .fault_cause(fault_cause),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic [31:0] nextPc);
    imem_ack   = ack;
    imem_rdata = rdata;
    ins_ready  = ready;
    npc        = nextPc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0000_3000);
    checkOutput("rst_valid", ins_valid, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_cause", fault_cause, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_ins", ins, 0);
    checkOutput("rst_cpc", cpc, 0);
  endtask

  // Request must already be visible; ack after lat waiting cycles.
  task automatic serviceFetch(input int lat, input logic [31:0] addr, input logic [31:0] data);
    int     n;
    fetch_t e;
    for (int i = 0; i < lat; i++) begin
      checkOutput("req_wait", imem_req, 1);
      checkOutput("addr_wait", imem_addr, addr);
      checkOutput("valid_wait", ins_valid, 0);
      tick();
    end
    checkOutput("req_ack", imem_req, 1);
    checkOutput("addr_ack", imem_addr, addr);
    sb.push_back('{addr: addr, data: data});
    applyStimulus(1'b1, data, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0);
    n = 1;
    while (!ins_valid && n < 8) begin
      tick();
      n++;
    end
    checkOutput("valid_lat", 32'(n), 1);
    checkOutput("req_hold", imem_req, 0);
    checkOutput("fault_hold", fault, 0);
    checkOutput("cause_hold", fault_cause, 0);
    checkOutput("sb_size", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("ins", ins, e.data);
      checkOutput("cpc", cpc, e.addr);
    end
  endtask

  task automatic retire(input logic [31:0] nextPc);
    applyStimulus(1'b0, 32'd0, 1'b1, nextPc);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, nextPc);
    expRetired = expRetired + 32'd1;
    checkOutput("retired", retired, expRetired);
    checkOutput("valid_retire", ins_valid, 0);
    if (nextPc[1:0] == 2'b00) begin
      checkOutput("req_next", imem_req, 1);
      checkOutput("addr_next", imem_addr, nextPc);
      checkOutput("fault_next", fault, 0);
    end
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
    tick();
    checkOutput("launch_req", imem_req, 1);
    checkOutput("launch_addr", imem_addr, 32'h0000_3000);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    #12;
    checkResetState();
    tick();

    // Zero-wait fetch from the reset address, then retire.
    releaseReset();
    serviceFetch(0, 32'h0000_3000, 32'h2002_0005);
    retire(32'h0000_3004);

    // Hold for five cycles with a stray ack that must be ignored.
    serviceFetch(0, 32'h0000_3004, 32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 32'hBAD0_BAD0, 1'b0, 32'h0000_3010);
      tick();
      checkOutput("hold_valid", ins_valid, 1);
      checkOutput("hold_ins", ins, 32'h1111_2222);
      checkOutput("hold_cpc", cpc, 32'h0000_3004);
      checkOutput("hold_req", imem_req, 0);
    end
    retire(32'h0000_3010);

    // Delayed memory and top-of-address-space npc.
    serviceFetch(3, 32'h0000_3010, 32'h3333_4444);
    retire(32'hFFFF_FFFC);
    serviceFetch(1, 32'hFFFF_FFFC, 32'h5555_6666);
    retire(32'h0000_0000);
    serviceFetch(2, 32'h0000_0000, 32'h7777_8888);

    // Misaligned npc faults; fault is sticky and ignores further inputs.
    retire(32'h0000_3006);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mis_fault", fault, 1);
      checkOutput("mis_cause", fault_cause, 2'b01);
      checkOutput("mis_req", imem_req, 0);
      checkOutput("mis_valid", ins_valid, 0);
      checkOutput("mis_retired", retired, expRetired);
      checkOutput("mis_ins", ins, 32'h7777_8888);
      applyStimulus(1'b1, 32'hCAFE_0000, 1'b1, 32'h0000_4000);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);

    // Asynchronous reset pulse out of FAULT.
    rst_n = 1'b0;
    #2;
    expRetired = 32'd0;
    checkResetState();
    tick();
    releaseReset();
    serviceFetch(0, 32'h0000_3000, 32'h0BAD_F00D);
    retire(32'h0000_3008);

    // Reset while a request is pending; ack during/after reset is dropped.
    tick();
    tick();
    checkOutput("pend_req", imem_req, 1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hFEED_FACE, 1'b0, 32'd0);
    #2;
    expRetired = 32'd0;
    checkOutput("async_req", imem_req, 0);
    checkOutput("async_valid", ins_valid, 0);
    checkOutput("async_retired", retired, 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("late_ack_valid", ins_valid, 0);
    checkOutput("late_ack_req", imem_req, 1);
    checkOutput("late_ack_ins", ins, 0);
    serviceFetch(0, 32'h0000_3000, 32'h1234_5678);
    retire(32'h0000_3004);

    // Memory never answers: request stays up for TIMEOUT cycles, then fault.
    n = 0;
    while (imem_req && n < 100) begin
      checkOutput("to_addr", imem_addr, 32'h0000_3004);
      n++;
      tick();
    end
    checkOutput("to_cycles", 32'(n), 16);
    checkOutput("to_fault", fault, 1);
    checkOutput("to_cause", fault_cause, 2'b10);
    checkOutput("to_req", imem_req, 0);
    checkOutput("to_retired", retired, expRetired);
    applyStimulus(1'b1, 32'h9999_9999, 1'b1, 32'h0000_3000);
    tick();
    tick();
    checkOutput("to_sticky", fault, 1);
    checkOutput("to_sticky_ins", ins, 32'h1234_5678);
    checkOutput("to_sticky_retired", retired, expRetired);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
